// File: rtl/draw_rect_ctl.sv
// Sprite position controller: follows the mouse, then drops under gravity,
// bounces off the screen bottom with damped velocity and comes to rest.
module draw_rect_ctl #(
  parameter int unsigned H_RES = 800,
  parameter int unsigned V_RES = 600,
  parameter int unsigned REC_W = 48,
  parameter int unsigned REC_H = 64,
  parameter int unsigned GRAV  = 1,
  parameter int unsigned V_MAX = 63,
  parameter int unsigned V_MIN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        mouse_left,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  output logic [11:0] xpos,
  output logic [11:0] ypos,
  output logic        busy
);

  localparam int unsigned X_MAX = H_RES - REC_W;
  localparam int unsigned Y_MAX = V_RES - REC_H;

  typedef enum logic [1:0] {IDLE, FALL, RISE, STOP} state_t;

  state_t      state;
  logic [7:0]  vel;
  logic        click_pend;
  logic        vblnk_d;
  logic        mouse_left_d;

  logic        tick;
  logic [11:0] x_clamp;
  logic [11:0] y_clamp;
  logic [8:0]  v_sum;
  logic [7:0]  v_fall;
  logic [12:0] y_fall;
  logic [7:0]  d_fall;
  logic [7:0]  v_rise;
  logic [11:0] y_rise;

  // Frame tick, mouse clamping and per-state motion arithmetic
  always_comb begin
    tick    = vblnk & ~vblnk_d;
    x_clamp = (mouse_xpos > 12'(X_MAX)) ? 12'(X_MAX) : mouse_xpos;
    y_clamp = (mouse_ypos > 12'(Y_MAX)) ? 12'(Y_MAX) : mouse_ypos;
    v_sum   = {1'b0, vel} + 9'(GRAV);
    v_fall  = (v_sum > 9'(V_MAX)) ? 8'(V_MAX) : v_sum[7:0];
    y_fall  = {1'b0, ypos} + 13'(v_fall);
    d_fall  = v_fall - (v_fall >> 2);
    v_rise  = vel - 8'(GRAV);
    y_rise  = (ypos > 12'(v_rise)) ? (ypos - 12'(v_rise)) : 12'd0;
  end

  // Edge detectors and click latch; a tick clears the latch ahead of a new click
  always_ff @(posedge clk) begin
    if (rst) begin
      vblnk_d      <= 1'b0;
      mouse_left_d <= 1'b0;
      click_pend   <= 1'b0;
    end else begin
      vblnk_d      <= vblnk;
      mouse_left_d <= mouse_left;
      if (tick)
        click_pend <= 1'b0;
      else if (mouse_left & ~mouse_left_d)
        click_pend <= 1'b1;
    end
  end

  // Motion FSM, advanced once per frame tick
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      vel   <= 8'd0;
      xpos  <= 12'd0;
      ypos  <= 12'd0;
      busy  <= 1'b0;
    end else if (tick) begin
      case (state)
        IDLE: begin
          xpos <= x_clamp;
          ypos <= y_clamp;
          if (click_pend) begin
            state <= FALL;
            vel   <= 8'd0;
            busy  <= 1'b1;
          end else begin
            busy  <= 1'b0;
          end
        end
        FALL: begin
          if (y_fall < 13'(Y_MAX)) begin
            ypos <= y_fall[11:0];
            vel  <= v_fall;
            busy <= 1'b1;
          end else begin
            ypos <= 12'(Y_MAX);
            if (d_fall < 8'(V_MIN)) begin
              state <= STOP;
              vel   <= 8'd0;
              busy  <= 1'b0;
            end else begin
              state <= RISE;
              vel   <= d_fall;
              busy  <= 1'b1;
            end
          end
        end
        RISE: begin
          busy <= 1'b1;
          if (v_rise == 8'd0) begin
            state <= FALL;
            vel   <= 8'd0;
          end else begin
            ypos <= y_rise;
            vel  <= v_rise;
          end
        end
        STOP: begin
          busy <= 1'b0;
          if (click_pend)
            state <= IDLE;
        end
        default: begin
          state <= IDLE;
          vel   <= 8'd0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Directed bench for draw_rect_ctl: mouse follow, clamping, drop/bounce
// trajectory, click filtering and reset during motion.
module tb_draw_rect_ctl;

  localparam int M_IDLE = 0;
  localparam int M_FALL = 1;
  localparam int M_RISE = 2;
  localparam int M_STOP = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        vblnk;
  logic        mouse_left;
  logic [11:0] mouse_xpos;
  logic [11:0] mouse_ypos;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  // reference trajectory state
  int m_state;
  int m_x;
  int m_y;
  int m_v;

  draw_rect_ctl dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .mouse_left (mouse_left),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .xpos       (xpos),
    .ypos       (ypos),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expectation
  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  // One short frame: a vblnk pulse then a few blanking-free cycles
  task automatic frame();
    @(negedge clk) vblnk = 1'b1;
    @(negedge clk);
    @(negedge clk) vblnk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Single-cycle left-button pulse between ticks
  task automatic click();
    @(negedge clk) mouse_left = 1'b1;
    @(negedge clk) mouse_left = 1'b0;
    @(negedge clk);
  endtask

  // Advance the gravity/bounce reference by one frame
  task automatic model_step();
    int nv;
    int ny;
    int d;
    if (m_state == M_FALL) begin
      nv = m_v + 1;
      if (nv > 63) nv = 63;
      ny = m_y + nv;
      if (ny < 536) begin
        m_y = ny;
        m_v = nv;
      end else begin
        m_y = 536;
        d = nv - nv / 4;
        if (d < 2) begin
          m_state = M_STOP;
          m_v = 0;
        end else begin
          m_state = M_RISE;
          m_v = d;
        end
      end
    end else if (m_state == M_RISE) begin
      nv = m_v - 1;
      if (nv == 0) begin
        m_state = M_FALL;
        m_v = 0;
      end else begin
        m_y = (m_y - nv < 0) ? 0 : m_y - nv;
        m_v = nv;
      end
    end
  endtask

  // Run frames against the reference until rest; optional click at frame click_at
  task automatic run_model(input int max_frames, input int click_at, input int first_drop,
                           input string tag);
    int prev_drop = first_drop;
    int drop;
    bit bounced = 1'b0;
    for (int i = 0; i < max_frames && m_state != M_STOP; i++) begin
      if (i == click_at) click();
      model_step();
      frame();
      check({tag, "_y"}, int'(ypos), m_y);
      check({tag, "_x"}, int'(xpos), m_x);
      check({tag, "_busy"}, int'(busy), (m_state == M_FALL || m_state == M_RISE) ? 1 : 0);
      if (bounced) begin
        drop = 536 - int'(ypos);
        check({tag, "_decay"}, (drop < prev_drop) ? 1 : 0, 1);
        prev_drop = drop;
        bounced = 1'b0;
      end
      if (ypos == 12'd536 && busy) bounced = 1'b1;
    end
    check({tag, "_rest"}, (m_state == M_STOP && !busy && ypos == 12'd536) ? 1 : 0, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    vblnk = 1'b0;
    mouse_left = 1'b0;
    mouse_xpos = 12'd100;
    mouse_ypos = 12'd200;
    repeat (2) @(negedge clk);
    check("rst_x", int'(xpos), 0);
    check("rst_y", int'(ypos), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    @(negedge clk);
    check("pre_tick_y", int'(ypos), 0);

    // mouse follow
    frame();
    check("idle_x", int'(xpos), 100);
    check("idle_y", int'(ypos), 200);
    check("idle_busy", int'(busy), 0);
    frame();
    check("idle2_y", int'(ypos), 200);

    // clamping
    mouse_xpos = 12'd900;
    mouse_ypos = 12'd700;
    frame();
    check("clamp_x", int'(xpos), 752);
    check("clamp_y", int'(ypos), 536);

    // drop from the top
    mouse_xpos = 12'd100;
    mouse_ypos = 12'd0;
    frame();
    check("drop_start_y", int'(ypos), 0);
    click();
    frame();
    check("drop_enter_y", int'(ypos), 0);
    check("drop_enter_busy", int'(busy), 1);
    for (int k = 1; k <= 32; k++) begin
      frame();
      check("drop_fall_y", int'(ypos), k * (k + 1) / 2);
      check("drop_fall_busy", int'(busy), 1);
      check("drop_fall_x", int'(xpos), 100);
    end
    frame();
    check("drop_bounce_y", int'(ypos), 536);
    check("drop_bounce_busy", int'(busy), 1);
    frame();
    check("drop_rise_y", int'(ypos), 512);

    // remaining bounces to rest
    m_state = M_RISE;
    m_x = 100;
    m_y = 512;
    m_v = 24;
    run_model(400, -1, 24, "decay");
    for (int i = 0; i < 10; i++) begin
      frame();
      check("rest_y", int'(ypos), 536);
      check("rest_busy", int'(busy), 0);
    end

    // restart, then a click mid-fall must change nothing
    click();
    frame();
    check("stop_to_idle_busy", int'(busy), 0);
    frame();
    check("refollow_y", int'(ypos), 0);
    click();
    frame();
    check("refall_busy", int'(busy), 1);
    m_state = M_FALL;
    m_x = 100;
    m_y = 0;
    m_v = 0;
    run_model(400, 10, 1000, "clickfall");

    // click in STOP: first tick holds position, next tick loads mouse
    mouse_xpos = 12'd300;
    mouse_ypos = 12'd400;
    click();
    frame();
    check("stopclk_y", int'(ypos), 536);
    check("stopclk_x", int'(xpos), 100);
    check("stopclk_busy", int'(busy), 0);
    frame();
    check("stopclk_next_x", int'(xpos), 300);
    check("stopclk_next_y", int'(ypos), 400);

    // held button yields a single FALL entry
    mouse_xpos = 12'd200;
    mouse_ypos = 12'd500;
    frame();
    @(negedge clk) mouse_left = 1'b1;
    frame();
    check("held_enter_y", int'(ypos), 500);
    check("held_enter_busy", int'(busy), 1);
    m_state = M_FALL;
    m_x = 200;
    m_y = 500;
    m_v = 0;
    run_model(200, -1, 1000, "held");
    for (int i = 0; i < 5; i++) begin
      frame();
      check("held_stop_busy", int'(busy), 0);
      check("held_stop_y", int'(ypos), 536);
    end
    @(negedge clk) mouse_left = 1'b0;

    // reset during RISE
    mouse_xpos = 12'd100;
    mouse_ypos = 12'd0;
    click();
    frame();
    frame();
    check("rr_idle_y", int'(ypos), 0);
    click();
    frame();
    repeat (33) frame();
    check("rr_bounce_y", int'(ypos), 536);
    frame();
    check("rr_rise_y", int'(ypos), 512);
    check("rr_rise_busy", int'(busy), 1);
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    check("rr_rst_x", int'(xpos), 0);
    check("rr_rst_y", int'(ypos), 0);
    check("rr_rst_busy", int'(busy), 0);
    rst = 1'b0;
    mouse_xpos = 12'd50;
    mouse_ypos = 12'd60;
    frame();
    check("rr_follow_x", int'(xpos), 50);
    check("rr_follow_y", int'(ypos), 60);
    check("rr_follow_busy", int'(busy), 0);
    mouse_ypos = 12'd70;
    frame();
    check("rr_follow2_y", int'(ypos), 70);
    check("rr_follow2_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
